// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write master: FSM states, phase constants
// and the expected tick count of a fully ACKed transaction.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP
    } state_t;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    localparam int START_TICKS = 2;
    localparam int BIT_TICKS   = 4;
    localparam int STOP_TICKS  = 3;

    localparam logic [1:0] START_LAST = 2'(START_TICKS - 1);
    localparam logic [1:0] STOP_LAST  = 2'(STOP_TICKS - 1);

    // Ticks spent outside IDLE for nbytes bytes, each 8 data bits plus an ACK slot.
    function automatic int txn_ticks(input int nbytes);
        return START_TICKS + BIT_TICKS * 9 * nbytes + STOP_TICKS;
    endfunction

endpackage

// File: rtl/i2c_write_master_if.sv
// Request/status and bus-pin bundle between the I2C write master and its
// surroundings (tick source, requester, SDA/SCL pads).
interface i2c_write_master_if #(
    parameter int DATA_BYTES = 2
);
    logic                    tick;
    logic                    start;
    logic [7:0]              dev_addr;
    logic [8*DATA_BYTES-1:0] reg_data;
    logic                    ready;
    logic                    ack_ok;
    logic                    nack;
    logic                    scl_o;
    logic                    sda_oe;
    logic                    sda_i;

    modport master (
        input  tick, start, dev_addr, reg_data, sda_i,
        output ready, ack_ok, nack, scl_o, sda_oe
    );

    modport slave (
        output tick, start, dev_addr, reg_data, sda_i,
        input  ready, ack_ok, nack, scl_o, sda_oe
    );

endinterface

// File: rtl/i2c_tick_gen.sv
// Free-running divider producing a one-clk pulse every DIV clocks; sits beside
// the write master and feeds its tick input at 4x the SCL rate.
module i2c_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/i2c_write_master.sv
// Write-only I2C master: START, address byte, DATA_BYTES payload bytes each
// followed by an ACK slot, then STOP. Timing is paced by an external 4x tick.
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int DATA_BYTES = 2
) (
    input  logic               clk,
    input  logic               reset,
    i2c_write_master_if.master bus
);
    localparam int NBYTES  = DATA_BYTES + 1;
    localparam int SHIFT_W = 8 * NBYTES;
    localparam int BYTE_W  = $clog2(NBYTES + 1);

    state_t              state, state_nx;
    logic [1:0]          phase;
    logic [2:0]          bit_cnt;
    logic [BYTE_W-1:0]   byte_cnt;
    logic [SHIFT_W-1:0]  shreg;
    logic [1:0]          sda_sync;
    logic                ack_bit;
    logic                ack_ok;
    logic                nack;
    logic                scl;
    logic                sda_pull;

    always_ff @(posedge clk) begin
        sda_sync <= {sda_sync[0], bus.sda_i};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            phase    <= PH0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            ack_bit  <= 1'b0;
            ack_ok   <= 1'b0;
            nack     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE) begin
                phase <= PH0;
                if (bus.start) begin
                    shreg    <= {bus.dev_addr, bus.reg_data};
                    bit_cnt  <= 3'd7;
                    byte_cnt <= '0;
                    ack_ok   <= 1'b0;
                    nack     <= 1'b0;
                end
            end else if (bus.tick) begin
                phase <= (state_nx != state) ? PH0 : phase + 2'd1;
                // The shift at the end of bit 0 also brings the next byte's MSB to the top.
                if (state == ST_BIT && phase == PH3) begin
                    shreg   <= {shreg[SHIFT_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt - 3'd1;
                end
                if (state == ST_ACK && phase == PH2)
                    ack_bit <= sda_sync[1];
                if (state == ST_ACK && phase == PH3) begin
                    byte_cnt <= byte_cnt + BYTE_W'(1);
                    if (ack_bit)
                        nack <= 1'b1;
                end
                if (state == ST_STOP && phase == STOP_LAST)
                    ack_ok <= ~nack;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nx = ST_START;
            ST_START: if (bus.tick && phase == START_LAST) state_nx = ST_BIT;
            ST_BIT:   if (bus.tick && phase == PH3 && bit_cnt == 3'd0) state_nx = ST_ACK;
            ST_ACK: begin
                if (bus.tick && phase == PH3)
                    state_nx = (ack_bit || byte_cnt == BYTE_W'(DATA_BYTES)) ? ST_STOP : ST_BIT;
            end
            ST_STOP:  if (bus.tick && phase == STOP_LAST) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        scl      = 1'b1;
        sda_pull = 1'b0;
        case (state)
            ST_START: sda_pull = (phase == PH1);
            ST_BIT: begin
                scl      = (phase == PH1) || (phase == PH2);
                sda_pull = ~shreg[SHIFT_W-1];
            end
            ST_ACK:   scl = (phase == PH1) || (phase == PH2);
            ST_STOP: begin
                scl      = (phase != PH0);
                sda_pull = (phase != STOP_LAST);
            end
            default: begin
                scl      = 1'b1;
                sda_pull = 1'b0;
            end
        endcase
    end

    assign bus.ready  = (state == ST_IDLE);
    assign bus.ack_ok = ack_ok;
    assign bus.nack   = nack;
    assign bus.scl_o  = scl;
    assign bus.sda_oe = sda_pull;

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for the I2C write master: a behavioural slave/bus monitor decodes the
// wire-level traffic and each transaction is compared with the bytes requested.
module tb_i2c_write_master;
    localparam int DATA_BYTES = 2;
    localparam int NB         = DATA_BYTES + 1;
    localparam int TIMEOUT    = 2000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    i2c_write_master_if #(.DATA_BYTES(DATA_BYTES)) bus ();

    i2c_tick_gen #(.DIV(4)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (bus.tick)
    );

    i2c_write_master #(.DATA_BYTES(DATA_BYTES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic slave_low = 1'b0;
    assign bus.sda_i = ~(bus.sda_oe | slave_low);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave and bus monitor state
    int         nack_at   = -1;
    int         ticks     = 0;
    int         starts    = 0;
    int         stops     = 0;
    int         viol      = 0;
    int         scl_rises = 0;
    int         bitpos    = 0;
    int         byte_idx  = 0;
    logic       busy      = 1'b0;
    logic       scl_q     = 1'b1;
    logic       sda_q     = 1'b1;
    logic [7:0] shift_in  = 8'h00;
    logic [7:0] got_q[$];
    logic       ack_q[$];

    always @(negedge clk) begin
        logic scl_now, sda_now;
        scl_now = bus.scl_o;
        sda_now = bus.sda_i;
        if (reset) begin
            busy      = 1'b0;
            bitpos    = 0;
            byte_idx  = 0;
            slave_low = 1'b0;
        end else begin
            if (!bus.ready && bus.tick) ticks++;
            if (!scl_q && scl_now) scl_rises++;
            if (scl_q && scl_now && (sda_q != sda_now)) begin
                if (!sda_now && !busy) begin
                    starts++;
                    busy     = 1'b1;
                    bitpos   = 0;
                    byte_idx = 0;
                end else if (sda_now && busy) begin
                    stops++;
                    busy = 1'b0;
                end else begin
                    viol++;
                end
            end
            if (busy && !scl_q && scl_now) begin
                if (bitpos < 8) shift_in = {shift_in[6:0], sda_now};
                else            ack_q.push_back(sda_now);
                bitpos++;
                if (bitpos == 8) got_q.push_back(shift_in);
            end
            if (busy && scl_q && !scl_now) begin
                if (bitpos == 8) begin
                    slave_low = (byte_idx != nack_at);
                end else if (bitpos == 9) begin
                    slave_low = 1'b0;
                    bitpos    = 0;
                    byte_idx++;
                end
            end
        end
        scl_q = scl_now;
        sda_q = sda_now;
    end

    task automatic clear_monitor();
        ticks = 0; starts = 0; stops = 0; viol = 0; scl_rises = 0;
        got_q.delete();
        ack_q.delete();
    endtask

    task automatic run_txn(input logic [7:0] addr, input logic [8*DATA_BYTES-1:0] data,
                           input int nack_byte, input bit disturb);
        logic [7:0] exp_b [NB];
        int         nsent;
        bit         exp_nack;
        int         cyc;
        int         rises_end;
        nack_at = nack_byte;
        clear_monitor();
        @(negedge clk);
        bus.dev_addr = addr;
        bus.reg_data = data;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("ready_drop", 32'(bus.ready), 32'd0);
        cyc = 0;
        while (!bus.ready && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
            if (disturb && cyc == 100) begin
                bus.start    = 1'b1;
                bus.dev_addr = ~addr;
                bus.reg_data = ~data;
            end
            if (disturb && cyc == 101) bus.start = 1'b0;
            if (disturb && cyc == 250) begin
                bus.start    = 1'b1;
                bus.reg_data = data ^ 16'h5A5A;
            end
            if (disturb && cyc == 251) bus.start = 1'b0;
        end
        check_eq("txn_done", 32'(cyc < TIMEOUT), 32'd1);

        exp_b[0] = addr;
        for (int i = 0; i < DATA_BYTES; i++)
            exp_b[i+1] = data[8*(DATA_BYTES-1-i) +: 8];
        exp_nack = (nack_byte >= 0) && (nack_byte < NB);
        nsent    = exp_nack ? nack_byte + 1 : NB;

        check_eq("ack_ok", 32'(bus.ack_ok), 32'(!exp_nack));
        check_eq("nack", 32'(bus.nack), 32'(exp_nack));
        check_eq("busy_ticks", 32'(ticks), 32'(2 + 36 * nsent + 3));
        check_eq("byte_count", 32'(got_q.size()), 32'(nsent));
        for (int i = 0; i < nsent; i++) begin
            check_eq($sformatf("byte%0d", i),
                     (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_b[i]));
            check_eq($sformatf("ackslot%0d", i),
                     (i < ack_q.size()) ? 32'(ack_q[i]) : 32'hDEAD, 32'(exp_nack && i == nack_byte));
        end
        check_eq("starts", 32'(starts), 32'd1);
        check_eq("stops", 32'(stops), 32'd1);
        check_eq("scl_pulses", 32'(scl_rises), 32'(9 * nsent + 1));
        rises_end = scl_rises;
        repeat (40) @(negedge clk);
        check_eq("quiet_after_stop", 32'(scl_rises), 32'(rises_end));
        check_eq("idle_ready", 32'(bus.ready), 32'd1);
        check_eq("flags_hold", 32'({bus.ack_ok, bus.nack}), 32'({!exp_nack, exp_nack}));
        check_eq("bus_viol", 32'(viol), 32'd0);
    endtask

    task automatic reset_mid_txn(input logic [7:0] addr, input logic [15:0] data);
        int cyc;
        nack_at = -1;
        clear_monitor();
        @(negedge clk);
        bus.dev_addr = addr;
        bus.reg_data = data;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (scl_rises < 13 && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reach_byte1", 32'(cyc < TIMEOUT), 32'd1);
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        check_eq("rst_scl", 32'(bus.scl_o), 32'd1);
        check_eq("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        check_eq("rst_ready", 32'(bus.ready), 32'd1);
        check_eq("rst_flags", 32'({bus.ack_ok, bus.nack}), 32'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check_eq("rst_start_ignored", 32'(bus.ready), 32'd1);
        viol = 0;
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dev_addr = 8'h00;
        bus.reg_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("init_ready", 32'(bus.ready), 32'd1);
        check_eq("init_ack_ok", 32'(bus.ack_ok), 32'd0);
        check_eq("init_nack", 32'(bus.nack), 32'd0);
        check_eq("init_scl", 32'(bus.scl_o), 32'd1);
        check_eq("init_sda_oe", 32'(bus.sda_oe), 32'd0);

        run_txn(8'h72, 16'h9803, -1, 1'b0);
        run_txn(8'h72, 16'h9803, 0, 1'b0);
        run_txn(8'h72, 16'hAF5C, 1, 1'b0);
        run_txn(8'h72, 16'hC3A5, -1, 1'b1);
        reset_mid_txn(8'h72, 16'h9803);
        run_txn(8'h72, 16'h9803, -1, 1'b0);

        for (int t = 0; t < 8; t++) begin
            int nb;
            nb = int'($urandom_range(0, 4)) - 1;
            run_txn(8'($urandom), 16'($urandom), nb, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 7)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_write_master.md
I2C_WRITE_MASTER -- requirements
Module: i2c_write_master

Interface
REQ-001 Parameter DATA_BYTES, default 2: payload bytes sent after the address byte (register byte, then data byte).
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 tick  input  1  one-clk enable pulse at 4x SCL rate; consecutive pulses SHALL be at least 4 clk apart.
REQ-005 start  input  1  transaction request, sampled only while ready=1.
REQ-006 dev_addr  input  8  address byte sent verbatim, including R/W bit 0 (e.g. 0x72).
REQ-007 reg_data  input  8*DATA_BYTES  payload, MSB byte first, MSB bit first.
REQ-008 ready  output  1  high when idle and able to accept start.
REQ-009 ack_ok  output  1  last transaction completed with every byte ACKed.
REQ-010 nack  output  1  last transaction aborted on a NACK.
REQ-011 scl_o  output  1  SCL level, push-pull.
REQ-012 sda_oe  output  1  1 = pull SDA low, 0 = release (open-drain).
REQ-013 sda_i  input  1  SDA pin level, asynchronous.

Function
REQ-014 States: IDLE, START, BIT, ACK, STOP; phase counter 0..3 advances only on tick.
REQ-015 IDLE: ready=1, SCL released high, sda_oe=0; start=1 latches dev_addr/reg_data, clears ack_ok and nack, drops ready next cycle, enters START.
REQ-016 start while ready=0 is ignored; inputs change mid-transaction have no effect.
REQ-017 START: 2 ticks; tick 1 SDA released/SCL high, tick 2 SDA low/SCL high; then BIT.
REQ-018 BIT: 4 ticks per bit; ph0 SCL low + drive data bit, ph1 SCL high, ph2 SCL high, ph3 SCL low; SDA changes only in ph0.
REQ-019 Bit counter 7 down to 0; after bit 0 enter ACK.
REQ-020 ACK: same 4-phase timing with sda_oe=0; synchronized sda_i sampled in ph2; 0 = ACK, 1 = NACK.
REQ-021 Byte counter 0..DATA_BYTES; ACK on byte < DATA_BYTES returns to BIT with next byte; ACK on last byte enters STOP.
REQ-022 NACK on any byte: set nack, skip remaining bytes, enter STOP.
REQ-023 STOP: 3 ticks; SCL low/SDA low, SCL high/SDA low, SCL high/SDA released; then IDLE.
REQ-024 On STOP exit: ready=1, ack_ok=!nack; both flags hold until next accepted start.
REQ-025 Full ACKed transaction occupies exactly 2 + 36*(DATA_BYTES+1) + 3 ticks (113 at default).
REQ-026 sda_i passes a 2-flop synchronizer before use.
REQ-027 No clock stretching, arbitration, or read support; SCL never sampled.

Reset
REQ-028 reset clears the transaction and forces IDLE on the next edge: ready=1, ack_ok=0, nack=0, scl_o=1, sda_oe=0, all counters 0.
REQ-029 Mid-transaction reset releases the bus in that cycle without issuing STOP; start on the same edge is ignored.

Structure
REQ-030 State encoding, phase constants and the per-transaction tick count belong in shared package i2c_pkg.
REQ-031 Tick generation is a separate sub-module, i2c_tick_gen, instantiated beside this block and not inside it.
REQ-032 Single always-block FSM plus a shift register; no derived clocks.

Verification
REQ-033 tick every 4 clk, slave ACKs all bytes, dev_addr=0x72, reg_data=0x9803 -> SDA bits 0x72,0x98,0x03 with three ACK slots, ready low for 113 ticks, ack_ok=1, nack=0.
REQ-034 Slave NACKs the address -> STOP follows the first ACK slot, nack=1, ack_ok=0, no further SCL pulses.
REQ-035 Slave NACKs the register byte (0xAF) -> STOP after the second ACK slot, nack=1.
REQ-036 start pulsed during a transaction, reg_data changed mid-transaction -> ignored; original bytes on bus.
REQ-037 reset asserted mid-bit of byte 1 -> next edge scl_o=1, sda_oe=0, ready=1, flags 0; a new start then completes normally.
REQ-038 Bus monitor throughout: SDA never changes while SCL high except at START/STOP.
